// File: rtl/bus_control_unit_pkg.sv
//------------------------------------------------------------------------------
// bus_control_unit_pkg
// Shared encodings for the basic-computer bus control unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bus_control_unit_pkg;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_AR   = 3'b001;
    localparam logic [2:0] SEL_PC   = 3'b010;
    localparam logic [2:0] SEL_DR   = 3'b011;
    localparam logic [2:0] SEL_AC   = 3'b100;
    localparam logic [2:0] SEL_IR   = 3'b101;
    localparam logic [2:0] SEL_TR   = 3'b110;
    localparam logic [2:0] SEL_MEM  = 3'b111;

    localparam int LD_AR = 0;
    localparam int LD_PC = 1;
    localparam int LD_DR = 2;
    localparam int LD_AC = 3;
    localparam int LD_IR = 4;
    localparam int LD_TR = 5;

    // INR and CLR share this indexing
    localparam int RG_AR = 0;
    localparam int RG_PC = 1;
    localparam int RG_DR = 2;
    localparam int RG_AC = 3;
    localparam int RG_TR = 4;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_LDA  = 3'd2;
    localparam logic [2:0] OP_STA  = 3'd3;
    localparam logic [2:0] OP_BUN  = 3'd4;
    localparam logic [2:0] OP_BSA  = 3'd5;
    localparam logic [2:0] OP_ISZ  = 3'd6;
    localparam logic [2:0] OP_RREF = 3'd7;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_ADD  = 2'b10;

    localparam int RR_CLA = 11;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_HLT = 0;

    typedef enum logic [2:0] {
        T0    = 3'd0,
        T1    = 3'd1,
        T2    = 3'd2,
        T3    = 3'd3,
        T4    = 3'd4,
        T5    = 3'd5,
        T6    = 3'd6,
        T_BAD = 3'd7
    } tstate_e;

    typedef struct packed {
        logic [2:0] sel;
        logic [5:0] ld;
        logic [4:0] inr;
        logic [4:0] clr;
        logic       rd;
        logic       wr;
        logic [1:0] alu;
        logic       sc_clr;
        logic       halt;
    } ctrl_t;

    function automatic logic [1:0] alu_for_op(input logic [2:0] op);
        case (op)
            OP_AND:  return ALU_AND;
            OP_ADD:  return ALU_ADD;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_control_unit_control_decode.sv
//------------------------------------------------------------------------------
// control_decode
// Combinational map from timing state and latched decode to bus controls.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_decode
    import bus_control_unit_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              active_i,
    input  logic [2:0]        sc_i,
    input  logic [2:0]        d_i,
    input  logic              i_i,
    input  logic [ADDR_W-1:0] ir_i,
    input  logic              ac_sign_i,
    input  logic              ac_zero_i,
    input  logic              dr_zero_i,
    output ctrl_t             ctrl_o
);

    logic w_skip;
    logic unused_ir;

    assign w_skip = (ir_i[RR_SPA] & ~ac_sign_i) |
                    (ir_i[RR_SNA] &  ac_sign_i) |
                    (ir_i[RR_SZA] &  ac_zero_i);

    assign unused_ir = ^{ir_i[10:6], ir_i[1]};

    always_comb begin
        ctrl_o = '0;
        case (tstate_e'(sc_i))
            T0: begin
                ctrl_o.sel        = SEL_PC;
                ctrl_o.ld[LD_AR]  = 1'b1;
            end
            T1: begin
                ctrl_o.sel        = SEL_MEM;
                ctrl_o.rd         = 1'b1;
                ctrl_o.ld[LD_IR]  = 1'b1;
                ctrl_o.inr[RG_PC] = 1'b1;
            end
            T2: begin
                ctrl_o.sel        = SEL_IR;
                ctrl_o.ld[LD_AR]  = 1'b1;
            end
            T3: begin
                if (d_i != OP_RREF) begin
                    if (i_i) begin
                        ctrl_o.sel       = SEL_MEM;
                        ctrl_o.rd        = 1'b1;
                        ctrl_o.ld[LD_AR] = 1'b1;
                    end
                end else begin
                    ctrl_o.sc_clr = 1'b1;
                    if (!i_i) begin
                        ctrl_o.clr[RG_AC] = ir_i[RR_CLA];
                        // Clear wins over increment so AC never sees both
                        ctrl_o.inr[RG_AC] = ir_i[RR_INC] & ~ir_i[RR_CLA];
                        ctrl_o.inr[RG_PC] = w_skip;
                        ctrl_o.halt       = ir_i[RR_HLT];
                    end
                end
            end
            T4: begin
                case (d_i)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        ctrl_o.sel       = SEL_MEM;
                        ctrl_o.rd        = 1'b1;
                        ctrl_o.ld[LD_DR] = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_o.sel    = SEL_AC;
                        ctrl_o.wr     = 1'b1;
                        ctrl_o.sc_clr = 1'b1;
                    end
                    OP_BUN: begin
                        ctrl_o.sel       = SEL_AR;
                        ctrl_o.ld[LD_PC] = 1'b1;
                        ctrl_o.sc_clr    = 1'b1;
                    end
                    OP_BSA: begin
                        ctrl_o.sel        = SEL_PC;
                        ctrl_o.wr         = 1'b1;
                        ctrl_o.inr[RG_AR] = 1'b1;
                    end
                    default: ctrl_o.sc_clr = 1'b1;
                endcase
            end
            T5: begin
                case (d_i)
                    OP_AND, OP_ADD, OP_LDA: begin
                        ctrl_o.ld[LD_AC] = 1'b1;
                        ctrl_o.alu       = alu_for_op(d_i);
                        ctrl_o.sc_clr    = 1'b1;
                    end
                    OP_BSA: begin
                        ctrl_o.sel       = SEL_AR;
                        ctrl_o.ld[LD_PC] = 1'b1;
                        ctrl_o.sc_clr    = 1'b1;
                    end
                    OP_ISZ: ctrl_o.inr[RG_DR] = 1'b1;
                    default: ctrl_o.sc_clr = 1'b1;
                endcase
            end
            T6: begin
                ctrl_o.sc_clr = 1'b1;
                if (d_i == OP_ISZ) begin
                    ctrl_o.sel        = SEL_DR;
                    ctrl_o.wr         = 1'b1;
                    ctrl_o.inr[RG_PC] = dr_zero_i;
                end
            end
            default: ctrl_o.sc_clr = 1'b1;
        endcase
        if (!active_i) begin
            ctrl_o = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_control_unit.sv
//------------------------------------------------------------------------------
// bus_control_unit
// Run flag, sequence counter and decode latches driving the common bus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_control_unit
    import bus_control_unit_pkg::*;
#(
    parameter bit AUTO_START = 1'b0,
    parameter int ADDR_W     = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ir_in,
    input  logic        ac_sign,
    input  logic        ac_zero,
    input  logic        dr_zero,
    output logic [2:0]  select,
    output logic [5:0]  LD,
    output logic [4:0]  INR,
    output logic [4:0]  CLR,
    output logic        read,
    output logic        write,
    output logic [1:0]  alu_op,
    output logic        busy,
    output logic [2:0]  sc
);

    logic              s_q, s_d;
    tstate_e           sc_q, sc_d;
    logic [2:0]        d_q, d_d;
    logic              i_q, i_d;
    logic [ADDR_W-1:0] ir_q, ir_d;
    ctrl_t             w_ctrl;
    logic              w_active;

    // Gating with reset keeps outputs quiet even when AUTO_START holds S high
    assign w_active = s_q & ~reset;

    control_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .active_i  (w_active),
        .sc_i      (sc_q),
        .d_i       (d_q),
        .i_i       (i_q),
        .ir_i      (ir_q),
        .ac_sign_i (ac_sign),
        .ac_zero_i (ac_zero),
        .dr_zero_i (dr_zero),
        .ctrl_o    (w_ctrl)
    );

    always_comb begin
        s_d  = s_q;
        sc_d = sc_q;
        d_d  = d_q;
        i_d  = i_q;
        ir_d = ir_q;
        if (s_q) begin
            if (w_ctrl.sc_clr) begin
                sc_d = T0;
            end else begin
                sc_d = tstate_e'(sc_q + 3'd1);
            end
            if (w_ctrl.halt) begin
                s_d = 1'b0;
            end
            if (sc_q == T2) begin
                i_d  = ir_in[15];
                d_d  = ir_in[14:12];
                ir_d = ir_in[ADDR_W-1:0];
            end
        end else if (start) begin
            s_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_q  <= AUTO_START;
            sc_q <= T0;
            d_q  <= '0;
            i_q  <= 1'b0;
            ir_q <= '0;
        end else begin
            s_q  <= s_d;
            sc_q <= sc_d;
            d_q  <= d_d;
            i_q  <= i_d;
            ir_q <= ir_d;
        end
    end

    assign select = w_ctrl.sel;
    assign LD     = w_ctrl.ld;
    assign INR    = w_ctrl.inr;
    assign CLR    = w_ctrl.clr;
    assign read   = w_ctrl.rd;
    assign write  = w_ctrl.wr;
    assign alu_op = w_ctrl.alu;
    assign busy   = s_q;
    assign sc     = sc_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_control_unit.sv
//------------------------------------------------------------------------------
// tb_bus_control_unit
// Scoreboard bench: instruction-level model queues per-cycle expectations.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] ir_in;
    logic        ac_sign, ac_zero, dr_zero;
    logic [2:0]  select;
    logic [5:0]  LD;
    logic [4:0]  INR, CLR;
    logic        read, write;
    logic [1:0]  alu_op;
    logic        busy;
    logic [2:0]  sc;

    typedef struct packed {
        logic [2:0] sel;
        logic [5:0] ld;
        logic [4:0] inr;
        logic [4:0] clr;
        logic       rd;
        logic       wr;
        logic [1:0] alu;
        logic       busy;
        logic [2:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_control_unit dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .ir_in   (ir_in),
        .ac_sign (ac_sign),
        .ac_zero (ac_zero),
        .dr_zero (dr_zero),
        .select  (select),
        .LD      (LD),
        .INR     (INR),
        .CLR     (CLR),
        .read    (read),
        .write   (write),
        .alu_op  (alu_op),
        .busy    (busy),
        .sc      (sc)
    );

    always #5 clock = ~clock;

    function automatic exp_t step(input int t);
        exp_t e;
        e      = '0;
        e.busy = 1'b1;
        e.sc   = t[2:0];
        return e;
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = {select, LD, INR, CLR, read, write, alu_op, busy, sc};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got sel=%b ld=%b inr=%b clr=%b rd=%b wr=%b alu=%b busy=%b sc=%0d, expected sel=%b ld=%b inr=%b clr=%b rd=%b wr=%b alu=%b busy=%b sc=%0d",
                     name, a.sel, a.ld, a.inr, a.clr, a.rd, a.wr, a.alu, a.busy, a.sc,
                     e.sel, e.ld, e.inr, e.clr, e.rd, e.wr, e.alu, e.busy, e.sc);
        end
    endtask

    // Instruction-level reference: register-transfer list per timing step
    task automatic push_instr(input logic [15:0] ir, input logic as, input logic az,
                              input logic dz, output int ncyc);
        exp_t       e;
        logic [2:0] op;
        logic       ind;
        op  = ir[14:12];
        ind = ir[15];
        e = step(0); e.sel = 3'b010; e.ld[0] = 1'b1; exp_q.push_back(e);
        e = step(1); e.sel = 3'b111; e.rd = 1'b1; e.ld[4] = 1'b1; e.inr[1] = 1'b1; exp_q.push_back(e);
        e = step(2); e.sel = 3'b101; e.ld[0] = 1'b1; exp_q.push_back(e);
        e = step(3);
        if (op == 3'd7) begin
            if (!ind) begin
                e.clr[3] = ir[11];
                e.inr[3] = ir[5] && !ir[11];
                e.inr[1] = (ir[4] && !as) || (ir[3] && as) || (ir[2] && az);
            end
            exp_q.push_back(e);
            ncyc = 4;
            return;
        end
        if (ind) begin
            e.sel = 3'b111; e.rd = 1'b1; e.ld[0] = 1'b1;
        end
        exp_q.push_back(e);
        e = step(4);
        case (op)
            3'd0, 3'd1, 3'd2: begin
                e.sel = 3'b111; e.rd = 1'b1; e.ld[2] = 1'b1; exp_q.push_back(e);
                e = step(5); e.ld[3] = 1'b1;
                e.alu = (op == 3'd0) ? 2'b01 : (op == 3'd1) ? 2'b10 : 2'b00;
                exp_q.push_back(e);
                ncyc = 6;
            end
            3'd3: begin
                e.sel = 3'b100; e.wr = 1'b1; exp_q.push_back(e);
                ncyc = 5;
            end
            3'd4: begin
                e.sel = 3'b001; e.ld[1] = 1'b1; exp_q.push_back(e);
                ncyc = 5;
            end
            3'd5: begin
                e.sel = 3'b010; e.wr = 1'b1; e.inr[0] = 1'b1; exp_q.push_back(e);
                e = step(5); e.sel = 3'b001; e.ld[1] = 1'b1; exp_q.push_back(e);
                ncyc = 6;
            end
            default: begin
                e.sel = 3'b111; e.rd = 1'b1; e.ld[2] = 1'b1; exp_q.push_back(e);
                e = step(5); e.inr[2] = 1'b1; exp_q.push_back(e);
                e = step(6); e.sel = 3'b011; e.wr = 1'b1; e.inr[1] = dz; exp_q.push_back(e);
                ncyc = 7;
            end
        endcase
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic as, input logic az, input logic dz);
        int n;
        ir_in   = ir;
        ac_sign = as;
        ac_zero = az;
        dr_zero = dz;
        push_instr(ir, as, az, dz, n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_t'(0));
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        exp_q.push_back(exp_t'(0));
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            compare("cycle", exp_q.pop_front());
        end
    end

    initial begin
        logic [15:0] r_ir;
        logic [2:0]  r_op;
        logic        r_i;
        int          n;

        reset = 1'b1; start = 1'b0; ir_in = '0;
        ac_sign = 1'b0; ac_zero = 1'b0; dr_zero = 1'b0;
        #1;
        compare("reset_state", exp_t'(0));
        @(posedge clock); #1;
        start = 1'b1;
        #1;
        compare("start_during_reset", exp_t'(0));
        start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        idle_cycles(2);

        do_start();
        run_instr(16'h7800, 1'b0, 1'b0, 1'b0);
        run_instr(16'h1005, 1'b0, 1'b0, 1'b0);
        run_instr(16'h9005, 1'b1, 1'b0, 1'b0);
        run_instr(16'h6010, 1'b0, 1'b0, 1'b1);
        run_instr(16'h6010, 1'b0, 1'b0, 1'b0);
        run_instr(16'h7020, 1'b0, 1'b0, 1'b0);
        run_instr(16'h7820, 1'b0, 1'b0, 1'b0);
        run_instr(16'h701C, 1'b1, 1'b1, 1'b0);
        run_instr(16'h7010, 1'b1, 1'b0, 1'b0);

        // Halt, stay idle, and a start pulse resumes at T0
        run_instr(16'h7001, 1'b0, 1'b0, 1'b0);
        idle_cycles(10);
        do_start();
        run_instr(16'h0123, 1'b0, 1'b0, 1'b0);

        // Reset while BSA sits in T4 with write asserted
        ir_in = 16'h5321;
        push_instr(16'h5321, 1'b0, 1'b0, 1'b0, n);
        void'(exp_q.pop_back());
        repeat (4) @(posedge clock);
        #6;
        reset = 1'b1;
        #1;
        compare("reset_async_bsa", exp_t'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        idle_cycles(2);
        do_start();

        for (int k = 0; k < 150; k++) begin
            r_op = 3'($urandom_range(0, 7));
            r_i  = 1'($urandom_range(0, 1));
            r_ir = {r_i, r_op, 12'($urandom)};
            if (r_op == 3'd7 && !r_i) r_ir[0] = 1'b0;
            run_instr(r_ir, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        @(negedge clock); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
